mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract sequencer.
- Time-multiplexes one 32-bit carry-lookahead word adder over an operand of 1..(2^CNT_W-1) 32-bit words, least-significant word first.
- Streams operand word pairs in and sum words out over valid/ready handshakes, carrying the word carry between beats.
- Sits between the operand-fetch logic and any wide-arithmetic consumer, for example a bignum or checksum unit.

Parameters:
- CNT_W, 4, width of the word-count field; the maximum operation length is 2^CNT_W-1 words.
- WORD_W, 32, datapath word width. Fixed at 32 because the word adder is 32-bit; any other value is a configuration error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- op_sub  in  1  sampled with start: 0 = A+B, 1 = A-B.
- num_words  in  CNT_W  sampled with start: number of words in the operation.
- busy  out  1  high from an accepted start until done.
- in_valid  in  1  an operand word pair is present.
- in_ready  out  1  the sequencer accepts the pair this cycle.
- a_word  in  WORD_W  operand A word.
- b_word  in  WORD_W  operand B word.
- out_valid  out  1  sum_word is valid.
- out_ready  in  1  the consumer accepts sum_word.
- sum_word  out  WORD_W  result word.
- out_last  out  1  marks the most-significant result word.
- done  out  1  one-cycle pulse when the final word has been accepted.
- carry_out  out  1  final carry; for subtract, 1 = no borrow (A>=B unsigned). Held until the next start.
- overflow  out  1  signed overflow of the full-width result. Held until the next start.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - busy, in_ready, out_valid, out_last, done, carry_out and overflow all 0.
  - sum_word=0; word counter=0; carry register=0.
- States:
  - IDLE -> RUN when start=1 and num_words!=0. Latch op_sub and num_words, counter=0, carry register=op_sub, clear carry_out and overflow.
  - start with num_words=0 is ignored: no busy, no done.
  - start outside IDLE is ignored.
  - RUN -> DRAIN when the input handshake for word num_words-1 completes.
  - DRAIN -> IDLE when the output handshake with out_last=1 completes. done pulses high in the cycle after that handshake, with busy low in that same cycle.
- Input side:
  - in_ready = (state==RUN) && (!out_valid || out_ready). This is a single output register with no bubble under continuous ready.
  - An input handshake (in_valid && in_ready) computes S = a_word + (b_word XOR {32{sub}}) + carry_reg.
  - On that edge: sum_word<=S, out_valid<=1, out_last<=(counter==num_words-1), carry_reg<=word carry-out, counter++.
- Output side:
  - An output handshake without a same-cycle input handshake clears out_valid.
  - sum_word and out_last are stable while out_valid && !out_ready.
- Latency: one cycle from input handshake to out_valid. Throughput is one word per cycle when in_valid and out_ready are held high.
- Final flags, registered on the last input handshake and held through IDLE:
  - carry_out = word carry-out.
  - overflow = (a_msb == b'_msb) && (S_msb != a_msb), where b' is the possibly inverted B.
- Counter never wraps: its maximum value is num_words, which is at most 2^CNT_W-1.
- Reset mid-operation: immediately returns to IDLE with all outputs at their reset values. Partial results are discarded and no done pulse is issued.

Decomposition:
- Package mp_add_pkg holds:
  - the state enum {IDLE, RUN, DRAIN}, 2 bits;
  - localparam WORD_W=32;
  - the CNT_W default.
- The word adder reuses the existing CLA_32bit, instanced once:
  - cin = carry register;
  - b = b_word XOR {32{sub}};
  - the registered carry comes from its cout.
- No other sub-module is needed; the FSM, counter and output register are local.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, then release → all outputs 0, in_ready=0; start with num_words=0 → busy stays 0, no done.
2. 2-word add A=0x00000001_FFFFFFFF, B=0x00000000_00000001, out_ready=1 → sum words 0x00000000 then 0x00000002 with out_last=1; carry_out=0, overflow=0; done one cycle after the last handshake.
3. 1-word subtract 5-7 → sum_word=0xFFFFFFFE, carry_out=0 (borrow), overflow=0; then 7-5 → 0x00000002, carry_out=1.
4. Signed overflow, 1-word add 0x7FFFFFFF+0x00000001 → 0x80000000, overflow=1, carry_out=0; 0xFFFFFFFF+0x00000001 → 0, carry_out=1, overflow=0.
5. Backpressure, 4-word add with in_valid=1 throughout and out_ready toggling 1,0,0,1,… → in_ready low whenever out_valid && !out_ready, sum_word stable while stalled, carries correct.
6. rst_n asserted in RUN after 2 of 4 words → out_valid=0 and busy=0 immediately, no done; a following 1-word add 3+4 returns 0x00000007.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  // Datapath word width; fixed by the 32-bit carry-lookahead word adder.
  localparam int WORD_W = 32;

  // Default width of the word-count field (operations of 1..15 words).
  localparam int CNT_W_DEF = 4;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : mp_add_pkg

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups, with each
// group's carry-out formed from its group generate/propagate terms.
module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;

  // Bit generate/propagate and per-group lookahead terms.
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Carries inside each group, and group carry-out from the group terms.
  always_comb begin
    // NOTE: every variable written here gets a value on every path (c is
    // defaulted first), so no latch can be inferred.
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
    end
    sum  = p ^ c[31:0];
    cout = c[32];
  end

endmodule : CLA_32bit

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: runs one 32-bit CLA over an
// operand of num_words words, LS word first, carrying between beats.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_sub,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] sum_word,
  output logic              out_last,
  output logic              done,
  output logic              carry_out,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic              sub_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  cnt;
  logic              carry_q;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] s;
  logic              s_cout;
  logic              start_ok;
  logic              in_hs;
  logic              out_hs;
  logic              last_in;

  // Subtract is A + ~B + 1: B is inverted here and the +1 enters as the
  // initial carry loaded at start.
  assign b_eff    = b_word ^ {WORD_W{sub_q}};
  assign start_ok = (state == IDLE) && start && (num_words != '0);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_in  = (cnt == (num_q - CNT_ONE));

  CLA_32bit u_cla (
    .a    (a_word),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (s),
    .cout (s_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (in_hs && last_in) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept a pair whenever the single output slot is free or
  // being emptied this cycle, so streaming runs without bubbles.
  always_comb begin
    busy     = (state != IDLE);
    in_ready = (state == RUN) && (!out_valid || out_ready);
  end

  // Operation context, word counter, carry chain, output slot and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q     <= 1'b0;
      num_q     <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      sum_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_hs && out_last;
      if (start_ok) begin
        sub_q     <= op_sub;
        num_q     <= num_words;
        cnt       <= '0;
        carry_q   <= op_sub;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end
      if (in_hs) begin
        sum_word  <= s;
        out_valid <= 1'b1;
        out_last  <= last_in;
        carry_q   <= s_cout;
        cnt       <= cnt + CNT_ONE;
        if (last_in) begin
          carry_out <= s_cout;
          overflow  <= (a_word[WORD_W-1] == b_eff[WORD_W-1]) &&
                       (s[WORD_W-1] != a_word[WORD_W-1]);
        end
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule : mp_add_sequencer

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: a wide-integer model predicts
// every result word and the final flags; a monitor compares on each cycle.
module tb_mp_add_sequencer;

  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op_sub;
  logic [CNT_W-1:0] num_words;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a_word;
  logic [31:0]      b_word;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      sum_word;
  logic             out_last;
  logic             done;
  logic             carry_out;
  logic             overflow;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  exp_t        exp_q[$];
  logic [31:0] last_sum = '0;
  logic        exp_carry;
  logic        exp_ovf;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum = '0;
  logic        prev_last = 1'b0;
  logic        last_hs_prev = 1'b0;

  mp_add_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .num_words (num_words),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .out_last  (out_last),
    .done      (done),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operand arithmetic: treat A and B as n*32-bit unsigned integers.
  task automatic model(input bit sub, input int n, input logic [511:0] a,
                       input logic [511:0] b, output logic [511:0] s,
                       output logic c, output logic ovf);
    logic [511:0] mask;
    logic [511:0] a_m;
    logic [511:0] bb_m;
    logic [512:0] full;
    int w;
    w = n * 32;
    mask = '0;
    for (int i = 0; i < w; i++) mask[i] = 1'b1;
    a_m  = a & mask;
    bb_m = (sub ? ~b : b) & mask;
    full = {1'b0, a_m} + {1'b0, bb_m} + {512'b0, sub};
    s    = full[511:0] & mask;
    c    = full[w];
    ovf  = (a_m[w-1] == bb_m[w-1]) && (s[w-1] != a_m[w-1]);
  endtask

  // Monitor: result words, output stability under stall, and done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      check("done_timing", 64'(done), 64'(last_hs_prev));
      if (done) begin
        done_cnt++;
        check("busy_with_done", 64'(busy), 64'd0);
      end
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_sum", 64'(sum_word), 64'(prev_sum));
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(sum_word), 64'hdead_beef_dead_beef);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum_word", 64'(sum_word), 64'(e.word));
          check("out_last", 64'(out_last), 64'(e.last));
        end
        last_sum = sum_word;
      end
      last_hs_prev = out_valid && out_ready && out_last;
      prev_stall   = out_valid && !out_ready;
      prev_sum     = sum_word;
      prev_last    = out_last;
    end
  end

  // Predict an operation and queue its expected words.
  task automatic predict(input bit sub, input int n, input logic [511:0] a,
                         input logic [511:0] b, output logic [511:0] s);
    exp_t e;
    model(sub, n, a, b, s, exp_carry, exp_ovf);
    for (int i = 0; i < n; i++) begin
      e.word = s[i*32 +: 32];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Issue start and stream all words; mode 1 toggles out_ready 1,0,0,1,...
  task automatic do_op(input bit sub, input int n, input logic [511:0] a,
                       input logic [511:0] b, input int mode);
    logic [511:0] s;
    int idx;
    int cyc;
    int d0;
    predict(sub, n, a, b, s);
    @(posedge clk); #1;
    start = 1'b1; op_sub = sub; num_words = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    idx = 0; cyc = 0; d0 = done_cnt;
    while (done_cnt == d0 && cyc < 200) begin
      in_valid  = (idx < n);
      a_word    = (idx < n) ? a[idx*32 +: 32] : 32'h0;
      b_word    = (idx < n) ? b[idx*32 +: 32] : 32'h0;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("op_completed", 64'(done_cnt - d0), 64'd1);
    check("carry_out", 64'(carry_out), 64'(exp_carry));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [511:0] s;
    int idx;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; num_words = '0;
    in_valid = 1'b0; a_word = '0; b_word = '0; out_ready = 1'b1;

    // 1. Reset, then a zero-length start that must be ignored.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outs", {58'd0, out_last, done, carry_out, overflow, 2'b0}, 64'd0);
    check("rst_sum", 64'(sum_word), 64'd0);
    @(posedge clk); #1;
    start = 1'b1; num_words = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_len_busy", 64'(busy), 64'd0);
    end

    // Pin the model with hand-computed results.
    model(1'b0, 2, 512'h1_FFFFFFFF, 512'h1, s, exp_carry, exp_ovf);
    check("model_2w_add", 64'(s[63:0]), 64'h00000002_00000000);
    model(1'b1, 1, 512'h5, 512'h7, s, exp_carry, exp_ovf);
    check("model_5m7", {31'd0, exp_carry, s[31:0]}, 64'h0_FFFFFFFE);

    // 2. Two-word add with carry between words.
    do_op(1'b0, 2, 512'h00000001_FFFFFFFF, 512'h00000000_00000001, 0);
    check("t2_last_word", 64'(last_sum), 64'h2);
    check("t2_flags", {62'd0, carry_out, overflow}, 64'd0);

    // 3. One-word subtracts, with and without borrow.
    do_op(1'b1, 1, 512'h5, 512'h7, 0);
    check("t3a_word", 64'(last_sum), 64'hFFFFFFFE);
    check("t3a_flags", {62'd0, carry_out, overflow}, 64'd0);
    do_op(1'b1, 1, 512'h7, 512'h5, 0);
    check("t3b_word", 64'(last_sum), 64'h2);
    check("t3b_carry", 64'(carry_out), 64'd1);

    // 4. Signed overflow and unsigned carry.
    do_op(1'b0, 1, 512'h7FFFFFFF, 512'h1, 0);
    check("t4a_word", 64'(last_sum), 64'h80000000);
    check("t4a_flags", {62'd0, carry_out, overflow}, 64'b01);
    do_op(1'b0, 1, 512'hFFFFFFFF, 512'h1, 0);
    check("t4b_word", 64'(last_sum), 64'h0);
    check("t4b_flags", {62'd0, carry_out, overflow}, 64'b10);

    // 5. Four-word add under output backpressure.
    model(1'b0, 4, 512'h80000000_FFFFFFFF_00000005_FFFFFFFF,
          512'h80000000_00000000_FFFFFFFB_00000001, s, exp_carry, exp_ovf);
    check("model_4w", 64'(s[127:64]), 64'h00000001_00000000);
    do_op(1'b0, 4, 512'h80000000_FFFFFFFF_00000005_FFFFFFFF,
          512'h80000000_00000000_FFFFFFFB_00000001, 1);
    check("t5_last_word", 64'(last_sum), 64'h1);
    check("t5_flags", {62'd0, carry_out, overflow}, 64'b11);

    // 6. Reset in RUN after two of four words, then a fresh operation.
    predict(1'b0, 4, 512'h4_00000003_00000002_00000001, 512'h1_00000001_00000001_00000001, s);
    @(posedge clk); #1;
    start = 1'b1; op_sub = 1'b0; num_words = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 50 && idx < 2; cyc++) begin
      in_valid = 1'b1;
      a_word = 32'(idx + 1);
      b_word = 32'h1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    check("t6_fed_two", 64'(idx), 64'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_done", 64'(done), 64'd0);
    do_op(1'b0, 1, 512'h3, 512'h4, 0);
    check("t6_word", 64'(last_sum), 64'h7);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mp_add_sequencer
